// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer: load-use bubbles, MULT/DIV wait, branch flush, stall counter.
// Latency: all stall/flush outputs are combinational from inputs and current state (zero cycles).
// Backpressure: drives PC/IF-ID enables low for a load-use cycle or for the whole MULT/DIV wait.
module hazard_stall_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_IdEx_MemRead,
  input  logic [4:0]             in_IdEx_RegisterRt,
  input  logic [4:0]             in_IfId_RegisterRs,
  input  logic [4:0]             in_IfId_RegisterRt,
  input  logic                   in_BranchTaken,
  input  logic                   in_MulDivStart,
  input  logic                   in_MulDivReady,
  input  logic                   in_StallCountClear,
  output logic                   EnablePC_Counter,
  output logic                   EnableIFtoID,
  output logic                   EnableControlSig,
  output logic                   FlushIFtoID,
  output logic                   MulDivGo,
  output logic                   MulDivBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  // One-hot style encoding; the two unused codes fall into the default arm and return to RUN.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b01,
    ST_MD_WAIT = 2'b10
  } state_t;

  // Counter preload: the wait lasts preload+1 cycles, i.e. exactly MULDIV_CYCLES.
  localparam logic [CNT_W-1:0]       MD_LOAD  = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0]   stall_q, stall_d;

  logic load_use;
  logic en_pc, en_ifid, en_ctl, flush, md_go, md_busy;

  // A load in EX whose destination (never $zero) feeds either source of the ID instruction.
  assign load_use = in_IdEx_MemRead
                  && (in_IdEx_RegisterRt != 5'd0)
                  && ((in_IdEx_RegisterRt == in_IfId_RegisterRs)
                   || (in_IdEx_RegisterRt == in_IfId_RegisterRt));

  // Next-state and raw stall/flush decisions; load-use beats MULT/DIV start beats branch flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_pc   = 1'b1;
    en_ifid = 1'b1;
    en_ctl  = 1'b1;
    flush   = 1'b0;
    md_go   = 1'b0;
    md_busy = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_use) begin
          // Freeze IF/ID and PC for one cycle and inject a bubble; the load moves on next cycle.
          en_pc   = 1'b0;
          en_ifid = 1'b0;
          en_ctl  = 1'b0;
        end else if (in_MulDivStart) begin
          // The MULT/DIV itself proceeds into EX; the stall starts on the following cycle.
          md_go   = 1'b1;
          state_d = ST_MD_WAIT;
          cnt_d   = MD_LOAD;
        end else if (in_BranchTaken) begin
          flush = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        // Branch and new MULT/DIV requests are ignored while the unit is busy.
        md_busy = 1'b1;
        en_pc   = 1'b0;
        en_ifid = 1'b0;
        en_ctl  = 1'b0;
        if ((cnt_q == '0) || in_MulDivReady) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating count of PC-stalled cycles; clear wins over increment.
  always_comb begin
    stall_d = stall_q;
    if (in_StallCountClear) begin
      stall_d = '0;
    end else if (!en_pc && (stall_q != '1)) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  // State, MULT/DIV down-counter and stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Outputs forced to their idle values while reset is held, so a reset mid-wait releases
  // the pipeline immediately even if the hazard inputs are still active.
  always_comb begin
    EnablePC_Counter = en_pc   | ~reset;
    EnableIFtoID     = en_ifid | ~reset;
    EnableControlSig = en_ctl  | ~reset;
    FlushIFtoID      = flush   & reset;
    MulDivGo         = md_go   & reset;
    MulDivBusy       = md_busy & reset;
  end

  assign StallCount = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int MDC = 4;
  localparam int SCW = 4;
  localparam int SAT = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           mr = 1'b0;
  logic [4:0]     ert = '0, rs = '0, rt = '0;
  logic           br = 1'b0, mds = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic           o_pc, o_ifid, o_ctl, o_flush, o_go, o_busy;
  logic [SCW-1:0] o_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles of MULT/DIV wait still to come (0 = running) and stall count.
  int m_left = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .MULDIV_CYCLES(MDC),
    .CNT_W(6),
    .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_IdEx_MemRead(mr),
    .in_IdEx_RegisterRt(ert),
    .in_IfId_RegisterRs(rs),
    .in_IfId_RegisterRt(rt),
    .in_BranchTaken(br),
    .in_MulDivStart(mds),
    .in_MulDivReady(rdy),
    .in_StallCountClear(clr),
    .EnablePC_Counter(o_pc),
    .EnableIFtoID(o_ifid),
    .EnableControlSig(o_ctl),
    .FlushIFtoID(o_flush),
    .MulDivGo(o_go),
    .MulDivBusy(o_busy),
    .StallCount(o_cnt)
  );

  wire [5:0] outs = {o_pc, o_ifid, o_ctl, o_flush, o_go, o_busy};

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] ert, rs, rt;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  task automatic drive(input logic a_mr, input logic [4:0] a_ert, input logic [4:0] a_rs,
                       input logic [4:0] a_rt, input logic a_br, input logic a_mds,
                       input logic a_rdy, input logic a_clr);
    mr = a_mr; ert = a_ert; rs = a_rs; rt = a_rt;
    br = a_br; mds = a_mds; rdy = a_rdy; clr = a_clr;
  endtask

  task automatic check_cnt(input string name, input int exp);
    vectors++;
    if (int'(o_cnt) != exp) begin
      miscompares++;
      $display("FAIL %s: StallCount got %0d expected %0d", name, o_cnt, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; checks, advances model, returns at
  // the next falling edge.
  task automatic step(input string name, input bit hand, input logic [5:0] hand_exp);
    logic [5:0] e;
    bit lu;
    #1;
    lu = mr && (ert != 0) && ((ert == rs) || (ert == rt));
    if (m_left > 0)  e = 6'b000001;
    else if (lu)     e = 6'b000000;
    else if (mds)    e = 6'b111010;
    else if (br)     e = 6'b111100;
    else             e = 6'b111000;
    vectors++;
    if ((outs != e) || (int'(o_cnt) != m_cnt)) begin
      miscompares++;
      $display("FAIL %s model: outs=%b cnt=%0d expected outs=%b cnt=%0d", name, outs, o_cnt, e, m_cnt);
    end
    if (hand) begin
      vectors++;
      if (outs != hand_exp) begin
        miscompares++;
        $display("FAIL %s: outs=%b expected %b", name, outs, hand_exp);
      end
    end
    if (m_left > 0) begin
      if (m_left == 1 || rdy) m_left = 0;
      else m_left = m_left - 1;
    end else if (!lu && mds) begin
      m_left = MDC;
    end
    if (clr) m_cnt = 0;
    else if (e[5] == 1'b0 && m_cnt < SAT) m_cnt = m_cnt + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{"loaduse_rs",  1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 6'b000000};
    tbl[1] = '{"noload",      1'b0, 5'd5,  5'd5, 5'd0,  1'b0, 6'b111000};
    tbl[2] = '{"rt_zero",     1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 6'b111000};
    tbl[3] = '{"branch",      1'b0, 5'd0,  5'd1, 5'd2,  1'b1, 6'b111100};
    tbl[4] = '{"branch_lu",   1'b1, 5'd7,  5'd1, 5'd7,  1'b1, 6'b000000};
    tbl[5] = '{"load_nomatch",1'b1, 5'd9,  5'd3, 5'd4,  1'b0, 6'b111000};
    tbl[6] = '{"loaduse_rt",  1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 6'b000000};

    // Reset held with a load-use pattern on the inputs: enables must still read 1.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #12;
    vectors++;
    if (outs != 6'b111000 || o_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_hold: outs=%b cnt=%0d expected 111000 cnt=0", outs, o_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_reset", 1'b1, 6'b111000);
    check_cnt("post_reset_cnt", 0);

    foreach (tbl[i]) begin
      drive(tbl[i].mr, tbl[i].ert, tbl[i].rs, tbl[i].rt, tbl[i].br, 1'b0, 1'b0, 1'b0);
      step(tbl[i].name, 1'b1, tbl[i].exp);
    end
    check_cnt("table_cnt", 3);

    // MULT/DIV full-length wait.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("clear", 1'b1, 6'b111000);
    check_cnt("clear_cnt", 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("md_go", 1'b1, 6'b111010);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < MDC; k++) step("md_wait", 1'b1, 6'b000001);
    step("md_done", 1'b1, 6'b111000);
    check_cnt("md_cnt", 4);

    // Early finish: ready in the 2nd wait cycle.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rdy_go", 1'b1, 6'b111010);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rdy_w1", 1'b1, 6'b000001);
    rdy = 1'b1;
    step("rdy_w2", 1'b1, 6'b000001);
    rdy = 1'b0;
    step("rdy_done", 1'b1, 6'b111000);
    check_cnt("rdy_cnt", 6);

    // Back-to-back, with start and branch held (ignored) during the wait.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("b2b_go1", 1'b1, 6'b111010);
    for (int k = 0; k < MDC; k++) step("b2b_wait1", 1'b1, 6'b000001);
    step("b2b_go2", 1'b1, 6'b111010);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < MDC; k++) step("b2b_wait2", 1'b1, 6'b000001);
    step("b2b_done", 1'b1, 6'b111000);
    check_cnt("b2b_cnt", 14);

    // Asynchronous reset during the 2nd wait cycle.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rst_go", 1'b1, 6'b111010);
    mds = 1'b0;
    step("rst_w1", 1'b1, 6'b000001);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (outs != 6'b111000 || o_cnt != 0) begin
      miscompares++;
      $display("FAIL async_reset: outs=%b cnt=%0d expected 111000 cnt=0", outs, o_cnt);
    end
    m_left = 0;
    m_cnt  = 0;
    @(negedge clk);
    reset = 1'b1;
    step("rst_release", 1'b1, 6'b111000);
    check_cnt("rst_cnt", 0);

    // Saturation, then clear coinciding with a stall.
    drive(1'b1, 5'd3, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step("sat_lu", 1'b1, 6'b000000);
    check_cnt("sat_cnt", 15);
    clr = 1'b1;
    step("sat_clr", 1'b1, 6'b000000);
    check_cnt("sat_clr_cnt", 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sat_idle", 1'b1, 6'b111000);
    check_cnt("sat_idle_cnt", 0);

    // Randomised traffic against the model; small register range makes hazards frequent.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 19) == 0));
      step("random", 1'b0, 6'b000000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Central pipeline stall/flush sequencer for the 5-stage MIPS core. It detects load-use hazards, sequences multi-cycle MULT/DIV stalls, issues IF/ID flushes for taken branches, and keeps a saturating stall-cycle performance counter. It sits beside the ID stage and drives the PC enable, the IF/ID register enable, the ID/EX control-bubble mux and the IF/ID flush.

Parameters:
MULDIV_CYCLES, 32, stall cycles per MULT/DIV operation; legal range 1..63.
CNT_W, 6, width of the MULT/DIV down-counter.
STALL_CNT_W, 16, width of the stall performance counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_IdEx_MemRead  input  1  instruction in EX is a load.
in_IdEx_RegisterRt  input  5  destination of the load in EX.
in_IfId_RegisterRs  input  5  rs of the instruction in ID.
in_IfId_RegisterRt  input  5  rt of the instruction in ID.
in_BranchTaken  input  1  branch/jump resolved taken in ID this cycle.
in_MulDivStart  input  1  the instruction in ID is MULT/MULTU/DIV/DIVU.
in_MulDivReady  input  1  MULT/DIV unit finished early; ends the wait.
in_StallCountClear  input  1  synchronous clear of the stall counter.
EnablePC_Counter  output  1  1 = PC updates.
EnableIFtoID  output  1  1 = IF/ID register loads.
EnableControlSig  output  1  0 = zero ID/EX control signals (bubble).
FlushIFtoID  output  1  1 = IF/ID loads a NOP.
MulDivGo  output  1  one-cycle start pulse to the MULT/DIV unit.
MulDivBusy  output  1  high while in MD_WAIT.
StallCount  output  STALL_CNT_W  number of cycles with EnablePC_Counter=0, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state=RUN, down-counter=0, StallCount=0. While reset is held: all three enables=1, FlushIFtoID=0, MulDivGo=0, MulDivBusy=0.
- load_use = in_IdEx_MemRead & (in_IdEx_RegisterRt != 0) & ((Rt == IfId_Rs) | (Rt == IfId_Rt)). This is combinational with zero latency.
- State RUN. Priority is load_use > in_MulDivStart > in_BranchTaken.
  - load_use: all three enables=0 in the same cycle; no flush; no MulDivGo; stay in RUN. A single bubble results, because the load advances next cycle.
  - Otherwise, in_MulDivStart: MulDivGo=1 and EnableControlSig=1 (the MULT/DIV instruction proceeds). PC and IF/ID enables=1 this cycle. Next state MD_WAIT with the counter loaded to MULDIV_CYCLES-1.
  - Otherwise, in_BranchTaken: FlushIFtoID=1 with all enables=1.
  - Otherwise: all enables=1 and no flush.
- State MD_WAIT:
  - Outputs: MulDivBusy=1, EnablePC_Counter=0, EnableIFtoID=0, EnableControlSig=0, FlushIFtoID=0, MulDivGo=0.
  - Inputs in_BranchTaken and in_MulDivStart are ignored.
  - If the counter is 0 or in_MulDivReady=1, next state is RUN. Otherwise the counter decrements.
  - Total stall is exactly MULDIV_CYCLES cycles when in_MulDivReady stays low.
  - With MULDIV_CYCLES=1, the block spends one cycle in MD_WAIT.
- Back-to-back MULT/DIV: on return to RUN the inputs are re-evaluated normally, so a second in_MulDivStart immediately re-enters MD_WAIT.
- StallCount:
  - Increments each clock where EnablePC_Counter=0 and it is below its maximum value.
  - Holds at all-ones once saturated.
  - in_StallCountClear has priority over increment; the counter reads 0 the next cycle.
- Reset asserted mid-MD_WAIT aborts the wait immediately. Outputs return to their reset values asynchronously.
- Unused state encodings recover to RUN.

Test Plan:
- Load-use: MemRead=1, IdEx_Rt=5, IfId_Rs=5 in RUN -> that cycle enables=000, flush=0. Next cycle with MemRead=0 -> enables=111. StallCount=1.
- Rt=0 exclusion: MemRead=1, IdEx_Rt=0, IfId_Rs=0 -> enables=111, no stall.
- Branch versus hazard: BranchTaken=1 alone -> FlushIFtoID=1, enables=111. BranchTaken=1 together with load_use -> enables=000, FlushIFtoID=0.
- MULT/DIV with MULDIV_CYCLES=4: MulDivStart=1 for one cycle -> MulDivGo=1 that cycle, then MulDivBusy=1 with enables=000 for exactly 4 cycles, then RUN. StallCount=4. Pulse MulDivReady in the 2nd wait cycle -> wait ends after 2 cycles.
- Async reset during MD_WAIT: drop reset at cycle 2 of the wait -> MulDivBusy=0 and enables=111 without a clock edge. After release: RUN, StallCount=0.
- Saturation and clear: STALL_CNT_W=4, hold load_use for 20 cycles -> StallCount stays at 15. Pulse clear with a stall in the same cycle -> StallCount=0.
